// File: rtl/serial_alu_wide.sv
// Bit-serial ALU for multi-byte operands, NSHIFT bits per cycle, LSB chunk first.
// Handles arithmetic, logic, compare and shift ops with arg2 extension and abort.
module serial_alu_wide #(
    parameter int NSHIFT    = 2,
    parameter int BYTE_BITS = 8,
    parameter int MAX_BYTES = 4,
    localparam int STEPS = MAX_BYTES * BYTE_BITS / NSHIFT,
    localparam int SB    = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int LB    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_abort,
    input  logic [3:0]        operation,
    input  logic [LB-1:0]     len_m1,
    input  logic [LB-1:0]     arg2_len_m1,
    input  logic              sext2,
    input  logic              upd_carry,
    input  logic              upd_other,
    input  logic [NSHIFT-1:0] data_in1,
    input  logic [NSHIFT-1:0] data_in2,
    output logic              active,
    output logic [NSHIFT-1:0] data_out,
    output logic              out_we,
    output logic              op_done,
    output logic [SB-1:0]     counter,
    output logic              flag_c,
    output logic              flag_v,
    output logic              flag_s,
    output logic              flag_z
);

    localparam int CPB = BYTE_BITS / NSHIFT;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_RCL = 4'd10;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    state_t          state_nx;
    logic [SB-1:0]   counter_nx;

    logic [3:0]      op_q;
    logic [LB-1:0]   len_q;
    logic [LB-1:0]   a2len_q;
    logic            sext_q;
    logic            updc_q;
    logic            updo_q;

    logic            carry_q;
    logic            sign2_q;
    logic            zero_q;

    logic [3:0]      op_s;
    logic [LB-1:0]   len_s;
    logic [LB-1:0]   a2len_s;
    logic            sext_s;
    logic            updc_s;
    logic            updo_s;

    logic            run;
    logic            first;
    logic            last;
    logic            a2_in;
    logic            a2_last;
    logic            accept;

    logic            arith;
    logic            logic_op;
    logic            shift_op;
    logic            inv;
    logic            wr;
    logic            cin0;
    logic            cin;

    logic [NSHIFT-1:0] a2;
    logic [NSHIFT-1:0] b;
    logic [NSHIFT-1:0] res;
    logic [NSHIFT:0]   sum;
    logic [NSHIFT:0]   shl;
    logic              carry_nx;
    logic              c_new;
    logic              v_new;
    logic              zacc;

    // Latched params drive the op once running; ports only matter at accept.
    always_comb begin
        run     = (state == RUN);
        op_s    = run ? op_q    : operation;
        len_s   = run ? len_q   : len_m1;
        a2len_s = run ? a2len_q : arg2_len_m1;
        sext_s  = run ? sext_q  : sext2;
        updc_s  = run ? updc_q  : upd_carry;
        updo_s  = run ? updo_q  : upd_other;
    end

    always_comb begin
        active  = run || op_valid;
        first   = (counter == '0);
        last    = int'(counter) == (int'(len_s) + 1) * CPB - 1;
        a2_in   = int'(counter) < (int'(a2len_s) + 1) * CPB;
        a2_last = int'(counter) == (int'(a2len_s) + 1) * CPB - 1;
        op_done = active && last && !(run && op_abort);
        op_ready = !run || op_done;
        accept  = op_valid && op_ready;
    end

    always_comb begin
        arith    = 1'b0;
        logic_op = 1'b0;
        shift_op = 1'b0;
        inv      = 1'b0;
        wr       = 1'b1;
        cin0     = 1'b0;
        case (op_s)
            OP_ADD: arith = 1'b1;
            OP_SUB: begin
                arith = 1'b1;
                inv   = 1'b1;
                cin0  = 1'b1;
            end
            OP_ADC: begin
                arith = 1'b1;
                cin0  = flag_c;
            end
            OP_SBC: begin
                arith = 1'b1;
                inv   = 1'b1;
                cin0  = flag_c;
            end
            OP_AND, OP_OR, OP_XOR, OP_MOV: logic_op = 1'b1;
            OP_CMP: begin
                arith = 1'b1;
                inv   = 1'b1;
                cin0  = 1'b1;
                wr    = 1'b0;
            end
            OP_SHL: shift_op = 1'b1;
            OP_RCL: begin
                shift_op = 1'b1;
                cin0     = flag_c;
            end
            default: wr = 1'b0;
        endcase
    end

    // Past its valid length arg2 reads as all-ones or zero.
    always_comb begin
        a2  = a2_in ? data_in2 : {NSHIFT{sext_s && sign2_q}};
        cin = first ? cin0 : carry_q;
        b   = inv ? ~a2 : a2;
        sum = {1'b0, data_in1} + {1'b0, b} + {{NSHIFT{1'b0}}, cin};
        shl = {data_in1, cin};
        res = '0;
        case (op_s)
            OP_AND: res = data_in1 & a2;
            OP_OR:  res = data_in1 | a2;
            OP_XOR: res = data_in1 ^ a2;
            OP_MOV: res = a2;
            default: begin
                if (arith) begin
                    res = sum[NSHIFT-1:0];
                end else if (shift_op) begin
                    res = shl[NSHIFT-1:0];
                end
            end
        endcase
    end

    always_comb begin
        carry_nx = 1'b0;
        c_new    = 1'b0;
        v_new    = 1'b0;
        if (arith) begin
            carry_nx = sum[NSHIFT];
            c_new    = sum[NSHIFT];
            v_new    = (data_in1[NSHIFT-1] == b[NSHIFT-1]) &&
                       (sum[NSHIFT-1] != data_in1[NSHIFT-1]);
        end else if (shift_op) begin
            carry_nx = data_in1[NSHIFT-1];
            c_new    = data_in1[NSHIFT-1];
            v_new    = res[NSHIFT-1] ^ data_in1[NSHIFT-1];
        end
        zacc = (first || zero_q) && (res == '0);
    end

    always_comb begin
        data_out = active ? res : '0;
        out_we   = active && wr;
    end

    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        if (!run) begin
            if (op_valid && !last) begin
                state_nx   = RUN;
                counter_nx = SB'(1);
            end
        end else if (op_abort) begin
            state_nx   = IDLE;
            counter_nx = '0;
        end else if (op_done) begin
            state_nx   = op_valid ? RUN : IDLE;
            counter_nx = '0;
        end else begin
            counter_nx = counter + SB'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_nx;
            counter <= counter_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= '0;
            len_q   <= '0;
            a2len_q <= '0;
            sext_q  <= 1'b0;
            updc_q  <= 1'b0;
            updo_q  <= 1'b0;
        end else if (accept) begin
            op_q    <= operation;
            len_q   <= len_m1;
            a2len_q <= arg2_len_m1;
            sext_q  <= sext2;
            updc_q  <= upd_carry;
            updo_q  <= upd_other;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry_q <= 1'b0;
            sign2_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (active) begin
            carry_q <= carry_nx;
            zero_q  <= zacc;
            if (a2_last) begin
                sign2_q <= data_in2[NSHIFT-1];
            end
        end
    end

    // Reserved ops leave all flags alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            flag_s <= 1'b0;
            flag_z <= 1'b0;
        end else if (op_done && wr || op_done && op_s == OP_CMP) begin
            if (updc_s) begin
                flag_c <= c_new;
                flag_v <= v_new;
            end
            if (updo_s) begin
                flag_s <= res[NSHIFT-1];
                flag_z <= zacc;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu_wide.sv
// Directed bench for serial_alu_wide: vector table plus handshake,
// abort and reset sequences.
module tb_serial_alu_wide;

    localparam int LB = 2;
    localparam int SB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic          op_abort;
    logic [3:0]    operation;
    logic [LB-1:0] len_m1;
    logic [LB-1:0] arg2_len_m1;
    logic          sext2;
    logic          upd_carry;
    logic          upd_other;
    logic [1:0]    data_in1;
    logic [1:0]    data_in2;
    logic          active;
    logic [1:0]    data_out;
    logic          out_we;
    logic          op_done;
    logic [SB-1:0] counter;
    logic          flag_c;
    logic          flag_v;
    logic          flag_s;
    logic          flag_z;

    always #5 clk = ~clk;

    serial_alu_wide dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_abort    (op_abort),
        .operation   (operation),
        .len_m1      (len_m1),
        .arg2_len_m1 (arg2_len_m1),
        .sext2       (sext2),
        .upd_carry   (upd_carry),
        .upd_other   (upd_other),
        .data_in1    (data_in1),
        .data_in2    (data_in2),
        .active      (active),
        .data_out    (data_out),
        .out_we      (out_we),
        .op_done     (op_done),
        .counter     (counter),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .flag_s      (flag_s),
        .flag_z      (flag_z)
    );

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  len;
        logic [1:0]  a2len;
        logic        sext;
        logic        updc;
        logic        updo;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] res;
        logic [3:0]  flags;
    } vec_t;

    vec_t vt[18];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {28'd0, flag_c, flag_v, flag_s, flag_z};
    endfunction

    task automatic drive(input vec_t v, input int i);
        operation   = v.op;
        len_m1      = v.len;
        arg2_len_m1 = v.a2len;
        sext2       = v.sext;
        upd_carry   = v.updc;
        upd_other   = v.updo;
        data_in1    = v.a1[2*i +: 2];
        data_in2    = v.a2[2*i +: 2];
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int          n;
        int          we;
        int          dn;
        int          act;
        int          cerr;
        logic        dl;
        logic [31:0] r;
        n    = (int'(v.len) + 1) * 4;
        we   = 0;
        dn   = 0;
        act  = 0;
        cerr = 0;
        dl   = 1'b0;
        r    = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            op_valid = (i == 0);
            drive(v, i);
            #1;
            if (active) act++;
            if (out_we) we++;
            if (op_done) dn++;
            if (int'(counter) != i) cerr++;
            if (i == n - 1) dl = op_done;
            r[2*i +: 2] = data_out;
        end
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        chk({nm, ".res"}, r, v.res);
        chk({nm, ".flags"}, flags_now(), {28'd0, v.flags});
        chk({nm, ".active"}, act, n);
        chk({nm, ".we"}, we, (v.op == 4'd8 || v.op > 4'd10) ? 0 : n);
        chk({nm, ".done"}, {dn[30:0], dl}, {31'd1, 1'b1});
        chk({nm, ".counter"}, cerr, 0);
    endtask

    initial begin
        vec_t        w;
        logic [31:0] r1;
        logic [31:0] r2;

        //                op     len  a2l  sx  uc  uo  a1            a2            res           cvsz
        vt[0]  = '{4'd0,  2'd1, 2'd1, 0, 1, 1, 32'h0000_12FF, 32'h0000_0001, 32'h0000_1300, 4'b0000};
        vt[1]  = '{4'd1,  2'd0, 2'd0, 0, 1, 1, 32'h0000_0080, 32'h0000_0001, 32'h0000_007F, 4'b1100};
        vt[2]  = '{4'd8,  2'd3, 2'd3, 0, 1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 4'b1001};
        vt[3]  = '{4'd0,  2'd3, 2'd0, 1, 1, 1, 32'h0000_0100, 32'h0000_00FF, 32'h0000_00FF, 4'b1000};
        vt[4]  = '{4'd2,  2'd0, 2'd0, 0, 1, 1, 32'h0000_0010, 32'h0000_0020, 32'h0000_0031, 4'b0000};
        vt[5]  = '{4'd0,  2'd3, 2'd0, 0, 1, 1, 32'h0000_0100, 32'h0000_00FF, 32'h0000_01FF, 4'b0000};
        vt[6]  = '{4'd3,  2'd0, 2'd0, 0, 1, 1, 32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 4'b1000};
        vt[7]  = '{4'd4,  2'd1, 2'd1, 0, 1, 1, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 4'b0000};
        vt[8]  = '{4'd5,  2'd0, 2'd0, 0, 1, 1, 32'h0000_0080, 32'h0000_0001, 32'h0000_0081, 4'b0010};
        vt[9]  = '{4'd6,  2'd0, 2'd0, 0, 1, 1, 32'h0000_00AA, 32'h0000_00AA, 32'h0000_0000, 4'b0001};
        vt[10] = '{4'd7,  2'd1, 2'd0, 1, 1, 1, 32'h0000_1234, 32'h0000_5580, 32'h0000_FF80, 4'b0010};
        vt[11] = '{4'd9,  2'd0, 2'd0, 0, 1, 1, 32'h0000_0081, 32'h0000_0000, 32'h0000_0002, 4'b1100};
        vt[12] = '{4'd10, 2'd0, 2'd0, 0, 1, 1, 32'h0000_0040, 32'h0000_0000, 32'h0000_0081, 4'b0110};
        vt[13] = '{4'd12, 2'd0, 2'd0, 0, 1, 1, 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 4'b0110};
        vt[14] = '{4'd1,  2'd3, 2'd3, 0, 1, 1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0010};
        vt[15] = '{4'd0,  2'd3, 2'd3, 0, 1, 1, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0110};
        vt[16] = '{4'd0,  2'd0, 2'd0, 0, 0, 1, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0000, 4'b0101};
        vt[17] = '{4'd2,  2'd2, 2'd2, 0, 1, 1, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 4'b0000};

        reset     = 1'b0;
        op_valid  = 1'b0;
        op_abort  = 1'b0;
        drive(vt[0], 0);
        #1;
        chk("rst.ready", {31'd0, op_ready}, 1);
        chk("rst.active", {31'd0, active}, 0);
        chk("rst.done_we", {30'd0, op_done, out_we}, 0);
        chk("rst.counter", {28'd0, counter}, 0);
        chk("rst.flags", flags_now(), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 18; k++) begin
            run_op(vt[k], $sformatf("v%0d", k));
        end

        // Back-to-back ADDs with op_valid held through the first op_done.
        w  = '{4'd0, 2'd0, 2'd0, 0, 1, 1, 32'h11, 32'h22, 32'h0, 4'b0000};
        r1 = '0;
        r2 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op_valid = 1'b1;
            drive(w, i);
            #1;
            r1[2*i +: 2] = data_out;
            if (i == 3) begin
                chk("b2b.done1", {30'd0, op_done, op_ready}, 3);
            end
        end
        w.a1 = 32'h05;
        w.a2 = 32'h06;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
            drive(w, i);
            #1;
            r2[2*i +: 2] = data_out;
            if (i == 0) begin
                chk("b2b.step0", {27'd0, counter, active}, 1);
            end
        end
        @(negedge clk);
        #1;
        chk("b2b.res1", r1, 32'h33);
        chk("b2b.res2", r2, 32'h0B);
        chk("b2b.idle", {31'd0, active}, 0);

        // Abort at step 2 of an op that would have set C, V and Z.
        w = '{4'd0, 2'd0, 2'd0, 0, 1, 1, 32'h80, 32'h80, 32'h0, 4'b0000};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op_valid = (i == 0);
            op_abort = (i == 2);
            drive(w, i);
            #1;
        end
        chk("abort.cycle", {30'd0, active, op_done}, 2);
        @(negedge clk);
        op_abort = 1'b0;
        #1;
        chk("abort.idle", {27'd0, counter, active}, 0);
        chk("abort.flags", flags_now(), 0);
        chk("abort.ready", {31'd0, op_ready}, 1);

        // Reset in the middle of a 4-byte op.
        w = '{4'd1, 2'd0, 2'd0, 0, 1, 1, 32'h00, 32'h01, 32'hFF, 4'b0010};
        run_op(w, "pre");
        w = '{4'd0, 2'd3, 2'd3, 0, 1, 1, 32'h1234_5678, 32'h1111_1111, 32'h0, 4'b0};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            op_valid = (i == 0);
            drive(w, i);
            #1;
        end
        chk("rst.mid_cnt", {28'd0, counter}, 3);
        reset = 1'b0;
        #1;
        chk("rst.mid_flags", flags_now(), 0);
        chk("rst.mid_act", {27'd0, counter, active}, 0);
        @(negedge clk);
        reset = 1'b1;
        w = '{4'd0, 2'd0, 2'd0, 0, 1, 1, 32'h01, 32'h01, 32'h02, 4'b0000};
        run_op(w, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
